// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } arb_state_t;

    localparam int TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin selector: a lone requester wins, contention goes to
// the port that was not granted last.
module arb_rr2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // One-hot grant from the request pair and the last winner's index
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates two requesters onto one single-cycle-ack SRAM port with a
// registered IDLE/BUSY/DONE sequencer and a per-transaction timeout.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_BYTES  = DATA_WIDTH / 8,
    parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p0_sel,
    input  logic                  p0_we,
    input  logic [NUM_BYTES-1:0]  p0_byte_en,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_din,
    output logic [DATA_WIDTH-1:0] p0_dout,
    output logic                  p0_ack,
    output logic                  p0_err,
    input  logic                  p1_sel,
    input  logic                  p1_we,
    input  logic [NUM_BYTES-1:0]  p1_byte_en,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_din,
    output logic [DATA_WIDTH-1:0] p1_dout,
    output logic                  p1_ack,
    output logic                  p1_err,
    output logic                  mem_sel,
    output logic                  mem_we,
    output logic [NUM_BYTES-1:0]  mem_byte_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    input  logic                  mem_ack
);

    // Counter compares against TIMEOUT-1 so BUSY lasts exactly TIMEOUT cycles.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    arb_state_t            state_r;
    logic [7:0]            cnt_r;
    logic                  last_grant_r;
    logic                  owner_r;
    logic [1:0]            ack_r;
    logic [1:0]            err_r;
    logic [DATA_WIDTH-1:0] dout0_r;
    logic [DATA_WIDTH-1:0] dout1_r;
    logic                  mem_sel_r;
    logic                  mem_we_r;
    logic [NUM_BYTES-1:0]  mem_byte_en_r;
    logic [ADDR_WIDTH-1:0] mem_addr_r;
    logic [DATA_WIDTH-1:0] mem_din_r;

    logic [1:0]            req_s;
    logic [1:0]            grant_s;
    logic                  win_we_s;
    logic [NUM_BYTES-1:0]  win_byte_en_s;
    logic [ADDR_WIDTH-1:0] win_addr_s;
    logic [DATA_WIDTH-1:0] win_din_s;

    assign req_s = {p1_sel, p0_sel};

    arb_rr2 u_arb (
        .req        (req_s),
        .last_grant (last_grant_r),
        .grant      (grant_s)
    );

    // Route the winning requester's transaction fields
    always_comb begin
        if (grant_s[1]) begin
            win_we_s      = p1_we;
            win_byte_en_s = p1_byte_en;
            win_addr_s    = p1_addr;
            win_din_s     = p1_din;
        end else begin
            win_we_s      = p0_we;
            win_byte_en_s = p0_byte_en;
            win_addr_s    = p0_addr;
            win_din_s     = p0_din;
        end
    end

    // Transaction sequencer; every output is a register of this block
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            cnt_r         <= 8'd0;
            last_grant_r  <= 1'b1;
            owner_r       <= 1'b0;
            ack_r         <= 2'b00;
            err_r         <= 2'b00;
            dout0_r       <= '0;
            dout1_r       <= '0;
            mem_sel_r     <= 1'b0;
            mem_we_r      <= 1'b0;
            mem_byte_en_r <= '0;
            mem_addr_r    <= '0;
            mem_din_r     <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ack_r <= 2'b00;
                    err_r <= 2'b00;
                    if (|req_s) begin
                        mem_sel_r     <= 1'b1;
                        mem_we_r      <= win_we_s;
                        mem_byte_en_r <= win_byte_en_s;
                        mem_addr_r    <= win_addr_s;
                        mem_din_r     <= win_din_s;
                        owner_r       <= grant_s[1];
                        last_grant_r  <= grant_s[1];
                        cnt_r         <= 8'd0;
                        state_r       <= ST_BUSY;
                    end else begin
                        mem_sel_r <= 1'b0;
                        mem_we_r  <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    // The SRAM writes on every cycle we is high, so strobe only once.
                    mem_we_r <= 1'b0;
                    if (mem_ack) begin
                        mem_sel_r <= 1'b0;
                        ack_r     <= owner_r ? 2'b10 : 2'b01;
                        if (owner_r) begin
                            dout1_r <= mem_dout;
                        end else begin
                            dout0_r <= mem_dout;
                        end
                        state_r <= ST_DONE;
                    end else if (cnt_r == TO_LAST) begin
                        mem_sel_r <= 1'b0;
                        ack_r     <= owner_r ? 2'b10 : 2'b01;
                        err_r     <= owner_r ? 2'b10 : 2'b01;
                        if (owner_r) begin
                            dout1_r <= '0;
                        end else begin
                            dout0_r <= '0;
                        end
                        state_r <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                ST_DONE: begin
                    ack_r     <= 2'b00;
                    err_r     <= 2'b00;
                    mem_sel_r <= 1'b0;
                    mem_we_r  <= 1'b0;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    ack_r     <= 2'b00;
                    err_r     <= 2'b00;
                    mem_sel_r <= 1'b0;
                    mem_we_r  <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    assign p0_ack      = ack_r[0];
    assign p1_ack      = ack_r[1];
    assign p0_err      = err_r[0];
    assign p1_err      = err_r[1];
    assign p0_dout     = dout0_r;
    assign p1_dout     = dout1_r;
    assign mem_sel     = mem_sel_r;
    assign mem_we      = mem_we_r;
    assign mem_byte_en = mem_byte_en_r;
    assign mem_addr    = mem_addr_r;
    assign mem_din     = mem_din_r;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: SRAM model, schedule-based reference model with a
// per-cycle compare, directed scenarios and a randomized two-requester phase.
module tb_sram_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NB = 4;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          p0_sel = 1'b0, p0_we = 1'b0, p1_sel = 1'b0, p1_we = 1'b0;
    logic [NB-1:0] p0_byte_en = '0, p1_byte_en = '0;
    logic [AW-1:0] p0_addr = '0, p1_addr = '0;
    logic [DW-1:0] p0_din = '0, p1_din = '0;
    logic [DW-1:0] p0_dout, p1_dout;
    logic          p0_ack, p0_err, p1_ack, p1_err;
    logic          mem_sel, mem_we, mem_ack;
    logic [NB-1:0] mem_byte_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din, mem_dout;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int we_total = 0;

    sram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BYTES(NB), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .p0_sel(p0_sel), .p0_we(p0_we), .p0_byte_en(p0_byte_en), .p0_addr(p0_addr),
        .p0_din(p0_din), .p0_dout(p0_dout), .p0_ack(p0_ack), .p0_err(p0_err),
        .p1_sel(p1_sel), .p1_we(p1_we), .p1_byte_en(p1_byte_en), .p1_addr(p1_addr),
        .p1_din(p1_din), .p1_dout(p1_dout), .p1_ack(p1_ack), .p1_err(p1_err),
        .mem_sel(mem_sel), .mem_we(mem_we), .mem_byte_en(mem_byte_en), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (mem_we) we_total <= we_total + 1;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        merge = old;
        for (int b = 0; b < 4; b++) if (be[b]) merge[8*b +: 8] = nw[8*b +: 8];
    endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    // SRAM: acks one cycle after a rising sel, optional spurious acks while sel is low
    logic [DW-1:0] sram [0:15] = '{default: 32'h0};
    logic          sel_d = 1'b0, ack_q = 1'b0, spur_q = 1'b0;
    logic          ack_en = 1'b1, spur_en = 1'b0;
    logic [DW-1:0] rdata_q = '0;

    always @(posedge clk) begin
        sel_d  <= mem_sel;
        ack_q  <= ack_en & mem_sel & ~sel_d;
        spur_q <= spur_en & ($urandom_range(0, 2) == 0);
        if (mem_sel & ~sel_d) rdata_q <= sram[mem_addr[3:0]];
        if (mem_sel & mem_we) sram[mem_addr[3:0]] <= merge(sram[mem_addr[3:0]], mem_din, mem_byte_en);
    end

    assign mem_ack  = ack_q | (spur_q & ~mem_sel);
    assign mem_dout = rdata_q;

    // Reference model: one scheduled transaction at a time
    logic [31:0] ref_mem [0:15] = '{default: 32'h0};
    bit          have = 1'b0, last = 1'b1, rec_port, rec_we, rec_to, win;
    int          g = 0, len = 0, free_at = 0, ack_at;
    logic [3:0]  rec_be;
    logic [31:0] rec_addr, rec_din, rec_data;
    bit          e_sel, e_we, e_a0, e_a1, e_e0, e_e1;

    always @(negedge clk) begin
        if (rst) begin
            chk("reset_ctl", {mem_sel, mem_we, p0_ack, p0_err, p1_ack, p1_err}, 6'b0);
            chk("reset_mem_fields", {mem_byte_en, mem_addr, mem_din}, 68'h0);
            chk("reset_douts", {p0_dout, p1_dout}, 64'h0);
            have = 1'b0; last = 1'b1; free_at = 0;
        end else begin
            ack_at = g + len + 1;
            e_sel  = have && (cyc >= g + 1) && (cyc <= g + len);
            e_we   = e_sel && (cyc == g + 1) && rec_we;
            e_a0   = have && (cyc == ack_at) && !rec_port;
            e_a1   = have && (cyc == ack_at) && rec_port;
            e_e0   = e_a0 && rec_to;
            e_e1   = e_a1 && rec_to;
            chk("ctl", {mem_sel, mem_we, p0_ack, p0_err, p1_ack, p1_err},
                {e_sel, e_we, e_a0, e_e0, e_a1, e_e1});
            if (e_sel) chk("mem_fields", {mem_byte_en, mem_addr, mem_din}, {rec_be, rec_addr, rec_din});
            if (e_a0 && (rec_to || !rec_we)) chk("p0_dout", p0_dout, rec_data);
            if (e_a1 && (rec_to || !rec_we)) chk("p1_dout", p1_dout, rec_data);
            if (cyc >= free_at && (p0_sel || p1_sel)) begin
                win      = (p0_sel && p1_sel) ? ~last : p1_sel;
                last     = win;
                rec_port = win;
                rec_we   = win ? p1_we : p0_we;
                rec_be   = win ? p1_byte_en : p0_byte_en;
                rec_addr = win ? p1_addr : p0_addr;
                rec_din  = win ? p1_din : p0_din;
                rec_to   = !ack_en;
                len      = ack_en ? 2 : TO;
                g        = cyc;
                free_at  = cyc + len + 2;
                have     = 1'b1;
                if (rec_we) ref_mem[rec_addr[3:0]] = merge(ref_mem[rec_addr[3:0]], rec_din, rec_be);
                rec_data = rec_to ? 32'h0 : ref_mem[rec_addr[3:0]];
            end
        end
    end

    task automatic drive(input bit port, input bit sel, input bit we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] din);
        if (port) begin
            p1_sel = sel; p1_we = we; p1_byte_en = be; p1_addr = addr; p1_din = din;
        end else begin
            p0_sel = sel; p0_we = we; p0_byte_en = be; p0_addr = addr; p0_din = din;
        end
    endtask

    task automatic run_txn(input bit port, input bit we, input logic [3:0] be,
                           input logic [31:0] addr, input logic [31:0] din,
                           output int t0, output int tack, output logic [31:0] dout, output bit err);
        @(posedge clk); #1;
        drive(port, 1'b1, we, be, addr, din);
        t0   = cyc;
        tack = -1;
        dout = 32'h0;
        err  = 1'b0;
        for (int i = 0; i < 40 && tack < 0; i++) begin
            @(negedge clk);
            if (port ? p1_ack : p0_ack) begin
                tack = cyc;
                dout = port ? p1_dout : p0_dout;
                err  = port ? p1_err : p0_err;
            end
        end
        if (tack < 0) chk("txn_ack_seen", 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(port, 1'b0, we, be, addr, din);
    endtask

    initial begin
        int          t0, tack, wb, nack, first_port;
        logic [31:0] d;
        bit          e, act0, act1;
        logic        a0, a1;
        int          ap [4];
        int          ac [4];

        repeat (3) @(posedge clk);
        #1;
        chk("init_mem_sel", mem_sel, 1'b0);
        chk("init_acks", {p0_ack, p1_ack, p0_err, p1_err}, 4'h0);
        rst = 1'b0;

        // p0 full write then read of the same word
        run_txn(1'b0, 1'b1, 4'hF, 32'h4, 32'hDEADBEEF, t0, tack, d, e);
        chk("wr_latency", tack - t0, 3);
        run_txn(1'b0, 1'b0, 4'hF, 32'h4, 32'h0, t0, tack, d, e);
        chk("rd_latency", tack - t0, 3);
        chk("rd_data", d, 32'hDEADBEEF);
        chk("rd_err", e, 1'b0);

        // p1 partial write of byte lane 1
        wb = we_total;
        run_txn(1'b1, 1'b1, 4'h2, 32'h4, 32'h0000AB00, t0, tack, d, e);
        chk("we_one_cycle", we_total - wb, 1);
        run_txn(1'b1, 1'b0, 4'hF, 32'h4, 32'h0, t0, tack, d, e);
        chk("p1_rd_data", d, 32'hDEADABEF);

        // Both requesting from reset alternate p0,p1,p0,p1
        @(posedge clk); #1;
        rst = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 4'hF, 32'h4, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst  = 1'b0;
        nack = 0;
        for (int i = 0; i < 40 && nack < 4; i++) begin
            @(negedge clk);
            if (p0_ack || p1_ack) begin
                ap[nack] = p1_ack ? 1 : 0;
                ac[nack] = cyc;
                if (nack == 0) chk("rr_first_data", p0_dout, 32'hDEADABEF);
                nack++;
            end
        end
        chk("rr_ack_count", nack, 4);
        @(posedge clk); #1;
        p0_sel = 1'b0; p1_sel = 1'b0;
        if (nack == 4) begin
            chk("rr_order", {ap[0][1:0], ap[1][1:0], ap[2][1:0], ap[3][1:0]}, 8'b00_01_00_01);
            chk("rr_spacing", {ac[1] - ac[0], ac[2] - ac[1], ac[3] - ac[2]}, {32'd4, 32'd4, 32'd4});
        end

        // No SRAM ack: timeout with err and zeroed data
        repeat (2) @(posedge clk);
        ack_en = 1'b0;
        run_txn(1'b0, 1'b0, 4'hF, 32'h4, 32'h0, t0, tack, d, e);
        chk("to_latency", tack - t0, TO + 1);
        chk("to_err", e, 1'b1);
        chk("to_dout", d, 32'h0);
        ack_en = 1'b1;
        run_txn(1'b0, 1'b0, 4'hF, 32'h4, 32'h0, t0, tack, d, e);
        chk("to_recover_latency", tack - t0, 3);
        chk("to_recover_data", d, 32'hDEADABEF);

        // Reset in the middle of a BUSY transaction
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b0, 4'hF, 32'h4, 32'h0);
        @(posedge clk); #1;
        chk("busy_before_rst", mem_sel, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_async_ctl", {mem_sel, mem_we, p0_ack, p0_err, p1_ack, p1_err}, 6'b0);
        drive(1'b0, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        first_port = -1;
        for (int i = 0; i < 20 && first_port < 0; i++) begin
            @(negedge clk);
            if (p0_ack || p1_ack) first_port = p1_ack ? 1 : 0;
        end
        chk("post_rst_first_grant", first_port, 0);
        @(posedge clk); #1;
        p0_sel = 1'b0;
        nack = 0;
        for (int i = 0; i < 20 && nack == 0; i++) begin
            @(negedge clk);
            if (p1_ack) nack = 1;
        end
        chk("post_rst_p1_served", nack, 1);
        @(posedge clk); #1;
        p1_sel = 1'b0;

        // Randomized traffic with spurious acks while idle
        spur_en = 1'b1;
        act0 = 1'b0; act1 = 1'b0;
        for (int k = 0; k < 3060; k++) begin
            @(negedge clk);
            a0 = p0_ack; a1 = p1_ack;
            @(posedge clk); #1;
            if (act0 && a0) begin p0_sel = 1'b0; act0 = 1'b0; end
            if (act1 && a1) begin p1_sel = 1'b0; act1 = 1'b0; end
            if (k < 3000 && !act0 && $urandom_range(0, 2) == 0) begin
                drive(1'b0, 1'b1, 1'($urandom), 4'($urandom), 32'($urandom_range(0, 15)), $urandom);
                act0 = 1'b1;
            end
            if (k < 3000 && !act1 && $urandom_range(0, 2) == 0) begin
                drive(1'b1, 1'b1, 1'($urandom), 4'($urandom), 32'($urandom_range(0, 15)), $urandom);
                act1 = 1'b1;
            end
        end
        chk("drain_idle", {act0, act1}, 2'b00);

        repeat (4) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
